// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the 4:1 mux scan controller
// and other blocks that drive the gate-level mux selects.
package mux_scan_pkg;

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  // The mux wires s1 to the channel LSB and s0 to the MSB.
  function automatic logic [1:0] ch_to_sel(
    input logic [CH_W-1:0] ch
  );
    return {ch[0], ch[1]};
  endfunction

endpackage

// File: rtl/mux_scan_sync2.sv
// Two-flop synchronizer for the asynchronous mux output y.
// Used only when MUX_SCAN_SYNC_IN_EN is defined.
module mux_scan_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Time-division scan controller for the 4:1 mux stage.
// Define MUX_SCAN_SYNC_IN_EN to synchronize y_in before sampling.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL  = 4,
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       s1,
  output logic       s0,
  input  logic       y_in,
  output logic [1:0] chan,
  output logic [3:0] frame,
  output logic       frame_valid,
  output logic       busy
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic y_s;

`ifdef MUX_SCAN_SYNC_IN_EN
  localparam int SAMP_I = SETTLE + 2;

  if (SETTLE < 0 || SETTLE > DWELL - 4) begin : g_bad_settle
    $error("mux_scan_ctrl: SETTLE must be 0..DWELL-4");
  end

  mux_scan_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (y_in),
    .q   (y_s)
  );
`else
  localparam int SAMP_I = SETTLE;

  if (SETTLE < 0 || SETTLE > DWELL - 2) begin : g_bad_settle
    $error("mux_scan_ctrl: SETTLE must be 0..DWELL-2");
  end

  assign y_s = y_in;
`endif

  localparam logic [CW-1:0] SAMP = CW'(SAMP_I);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [CH_W-1:0]   chan_q;
  logic [NUM_CH-1:0] shadow;

  assign chan     = chan_q;
  assign {s1, s0} = ch_to_sel(chan_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      chan_q      <= '0;
      shadow      <= '0;
      frame       <= '0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt    <= '0;
          chan_q <= '0;
          if (en) begin
            state <= SCAN;
            busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (cnt == SAMP) shadow[chan_q] <= y_s;
          if (cnt == LAST) begin
            cnt    <= '0;
            chan_q <= chan_q + CH_W'(1);
            // Shadow is complete here since the sample point precedes LAST.
            if (chan_q == LAST_CH) begin
              frame       <= shadow;
              frame_valid <= 1'b1;
              if (!en) begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl with a behavioural 4:1 mux
// model feeding y_in, including a switch-cycle glitch on every channel.
module tb_mux_scan_ctrl;

`ifdef MUX_SCAN_SYNC_IN_EN
  localparam int D = 6;
`else
  localparam int D = 4;
`endif
  localparam int S = 1;
  localparam int NV = 4 * D + 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       s1, s0, y_in;
  logic [1:0] chan;
  logic [3:0] frame;
  logic       frame_valid, busy;

  logic [3:0] pat = 4'b0000;
  logic [1:0] sel_prev = 2'b00;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mux_scan_ctrl #(.DWELL(D), .SETTLE(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .s1          (s1),
    .s0          (s0),
    .y_in        (y_in),
    .chan        (chan),
    .frame       (frame),
    .frame_valid (frame_valid),
    .busy        (busy)
  );

  // Mux model: a=sel 00, b=s1 only, c=s0 only, d=both.
  // Output is inverted during the first cycle after a select change.
  always_ff @(posedge clk) sel_prev <= {s1, s0};

  always_comb begin
    logic [1:0] idx;
    idx  = {s0, s1};
    y_in = pat[idx] ^ ({s1, s0} != sel_prev);
  end

  typedef struct {
    logic [1:0] ch;
    logic [1:0] sel;
    logic       bsy;
    logic       fv;
  } vec_t;

  vec_t vt[NV];
  logic [1:0] sel_tab[4];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fv(input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_valid && n < limit);
    check("fv_seen", int'(frame_valid), 1);
  endtask

  initial begin
    int n;

    sel_tab[0] = 2'b00;
    sel_tab[1] = 2'b10;
    sel_tab[2] = 2'b01;
    sel_tab[3] = 2'b11;
    for (int i = 0; i < NV; i++) begin
      if (i < 4 * D) begin
        vt[i].ch  = 2'(i / D);
        vt[i].bsy = 1'b1;
        vt[i].fv  = 1'b0;
      end else begin
        vt[i].ch  = 2'd0;
        vt[i].bsy = 1'b0;
        vt[i].fv  = (i == 4 * D);
      end
      vt[i].sel = sel_tab[vt[i].ch];
    end

    // Reset then idle
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_outs", int'({chan, s1, s0, frame, frame_valid, busy}), 0);
    end

    // Single frame, en pulsed for one cycle
    pat = 4'b1101;
    en  = 1'b1;
    step();
    en  = 1'b0;
    for (int i = 0; i < NV; i++) begin
      check("sf_chan", int'(chan), int'(vt[i].ch));
      check("sf_sel", int'({s1, s0}), int'(vt[i].sel));
      check("sf_busy", int'(busy), int'(vt[i].bsy));
      check("sf_fv", int'(frame_valid), int'(vt[i].fv));
      if (vt[i].fv) check("sf_frame", int'(frame), 13);
      step();
    end
    check("sf_frame_hold", int'(frame), 13);

    // Continuous scan with a pattern change after the first frame
    pat = 4'b1101;
    en  = 1'b1;
    wait_fv(4 * D + 8, n);
    check("cs_latency", n, 4 * D + 1);
    check("cs_frame1", int'(frame), 13);
    pat = 4'b0010;
    wait_fv(4 * D + 8, n);
    check("cs_period1", n, 4 * D);
    check("cs_frame2", int'(frame), 2);
    step();
    check("cs_pulse_len", int'(frame_valid), 0);
    check("cs_busy", int'(busy), 1);

    // en dropped during ch1: frame still completes
    repeat (D) step();
    check("md_chan1", int'(chan), 1);
    pat = 4'b0110;
    en  = 1'b0;
    wait_fv(4 * D + 8, n);
    check("md_period", n, 3 * D - 1);
    check("md_frame", int'(frame), 6);
    step();
    check("md_idle", int'({busy, frame_valid, chan}), 0);
    n = 0;
    for (int i = 0; i < 3 * D; i++) begin
      step();
      n += int'(frame_valid);
    end
    check("md_no_more_fv", n, 0);

    // rst during ch2 discards the frame
    en = 1'b1;
    repeat (2 * D + 1) step();
    check("rs_chan2", int'(chan), 2);
    rst = 1'b1;
    step();
    check("rs_state", int'({chan, busy, frame_valid, frame}), 0);
    rst = 1'b0;
    en  = 1'b0;
    n = 0;
    for (int i = 0; i < 4 * D + 4; i++) begin
      step();
      n += int'(frame_valid);
    end
    check("rs_no_fv", n, 0);
    check("rs_frame", int'(frame), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
